// File: rtl/cmd_arbiter_if.sv
// cmd_arbiter_if: requester, controller and status signals of the command arbiter.
//   master modport: arbiter side (drives grants, done, response, controller start/operands/timeout).
//   slave modport:  environment side (requesters and command controller).
interface cmd_arbiter_if;
    logic        iReq0;
    logic        iReq1;
    logic [5:0]  iReq0_index;
    logic [5:0]  iReq1_index;
    logic [31:0] iReq0_argument;
    logic [31:0] iReq1_argument;
    logic        oGnt0;
    logic        oGnt1;
    logic        oDone0;
    logic        oDone1;
    logic [37:0] oResponse;
    logic        oIndex_error;
    logic        oTimeout_err;
    logic        oBusy;
    logic        iCtl_idle;
    logic        oNew_command;
    logic [5:0]  oCmd_index;
    logic [31:0] oCmd_argument;
    logic        iCmd_complete;
    logic [37:0] iResponse;
    logic        iIndex_error;
    logic        oTimeout_enable;
    logic        oTimeout;

    modport master (
        input  iReq0, iReq1, iReq0_index, iReq1_index, iReq0_argument, iReq1_argument,
        input  iCtl_idle, iCmd_complete, iResponse, iIndex_error,
        output oGnt0, oGnt1, oDone0, oDone1, oResponse, oIndex_error, oTimeout_err, oBusy,
        output oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
    );

    modport slave (
        output iReq0, iReq1, iReq0_index, iReq1_index, iReq0_argument, iReq1_argument,
        output iCtl_idle, iCmd_complete, iResponse, iIndex_error,
        input  oGnt0, oGnt1, oDone0, oDone1, oResponse, oIndex_error, oTimeout_err, oBusy,
        input  oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
    );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter feeding two requesters' commands to one command controller,
// with a per-command timeout.
//   iClock_host : sole clock, rising edge
//   iReset_n    : asynchronous active-low reset
//   bus         : cmd_arbiter_if.master (requests/grants/done, controller handshake, response)
module cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic          iClock_host,
    input  logic          iReset_n,
    cmd_arbiter_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             lastServed;
    logic             current;
    logic             winner;
    logic             active;
    logic             completeHit;
    logic             timeoutHit;

    // On contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        winner      = (bus.iReq0 && bus.iReq1) ? ~lastServed : bus.iReq1;
        active      = (state == ISSUE) || (state == WAIT);
        completeHit = (state == WAIT) && bus.iCmd_complete;
        // Completion arriving with the counter at zero takes priority over the timeout.
        timeoutHit  = active && (count == '0) && !bus.iCmd_complete;
    end

    assign bus.oBusy           = state != IDLE;
    assign bus.oNew_command    = state == ISSUE;
    assign bus.oTimeout_enable = active;

    always_ff @(posedge iClock_host or negedge iReset_n) begin
        if (!iReset_n) begin
            state             <= IDLE;
            count             <= '0;
            lastServed        <= 1'b1;
            current           <= 1'b0;
            bus.oGnt0         <= 1'b0;
            bus.oGnt1         <= 1'b0;
            bus.oDone0        <= 1'b0;
            bus.oDone1        <= 1'b0;
            bus.oTimeout      <= 1'b0;
            bus.oTimeout_err  <= 1'b0;
            bus.oResponse     <= '0;
            bus.oIndex_error  <= 1'b0;
            bus.oCmd_index    <= '0;
            bus.oCmd_argument <= '0;
        end else begin
            bus.oGnt0    <= 1'b0;
            bus.oGnt1    <= 1'b0;
            bus.oDone0   <= 1'b0;
            bus.oDone1   <= 1'b0;
            bus.oTimeout <= 1'b0;
            if (active)
                count <= (count == '0) ? count : count - 1'b1;
            case (state)
                IDLE: if (bus.iCtl_idle && (bus.iReq0 || bus.iReq1)) begin
                    state             <= ISSUE;
                    current           <= winner;
                    bus.oGnt0         <= ~winner;
                    bus.oGnt1         <= winner;
                    bus.oCmd_index    <= winner ? bus.iReq1_index : bus.iReq0_index;
                    bus.oCmd_argument <= winner ? bus.iReq1_argument : bus.iReq0_argument;
                    count             <= CNT_W'(TIMEOUT_CYCLES - 1);
                end
                ISSUE: if (!bus.iCtl_idle) state <= WAIT;
                DONE: begin
                    lastServed <= current;
                    state      <= IDLE;
                end
                default: ;
            endcase
            // Both ways of finishing a command pass through DONE and pulse the served oDone.
            if (completeHit || timeoutHit) begin
                state      <= DONE;
                bus.oDone0 <= ~current;
                bus.oDone1 <= current;
            end
            if (completeHit) begin
                bus.oResponse    <= bus.iResponse;
                bus.oIndex_error <= bus.iIndex_error;
                bus.oTimeout_err <= 1'b0;
            end
            if (timeoutHit) begin
                bus.oTimeout     <= 1'b1;
                bus.oTimeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: directed and randomized checks of cmd_arbiter against a command-level model.
module tb_cmd_arbiter;
    localparam int T = 8;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    int checks = 0;
    int errors = 0;

    // Reference model: who was served last and what the result registers should hold.
    int lastServed = 1;
    logic [37:0] mResp = '0;
    logic mIerr = 1'b0;
    logic mTerr = 1'b0;

    always #5 clock = ~clock;

    cmd_arbiter_if bus();

    cmd_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .iClock_host(clock),
        .iReset_n(resetN),
        .bus(bus)
    );

    logic [7:0] flags;
    logic [39:0] result;
    assign flags  = {bus.oBusy, bus.oGnt0, bus.oGnt1, bus.oDone0, bus.oDone1,
                     bus.oTimeout, bus.oNew_command, bus.oTimeout_enable};
    assign result = {bus.oResponse, bus.oIndex_error, bus.oTimeout_err};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command starting in an IDLE cycle (1 time unit after the edge) and ending in the
    // following IDLE cycle. busyWait: IDLE cycles with the controller busy; hold: extra ISSUE
    // cycles with the controller still idle; cdel: WAIT cycles before completion (<0 = never).
    task automatic doCmd(input bit r0, input bit r1, input logic [5:0] i0, input logic [5:0] i1,
                         input logic [31:0] a0, input logic [31:0] a1, input int busyWait,
                         input int hold, input int cdel, input logic [37:0] resp, input logic ierr);
        int w;
        int kc;
        bit timedOut;
        w = (r0 && r1) ? (lastServed == 0 ? 1 : 0) : (r0 ? 0 : 1);
        kc = (cdel < 0) ? 1000 : hold + 1 + cdel;
        timedOut = kc > T - 1;
        bus.iReq0 = r0;
        bus.iReq1 = r1;
        bus.iReq0_index = i0;
        bus.iReq1_index = i1;
        bus.iReq0_argument = a0;
        bus.iReq1_argument = a1;
        bus.iCtl_idle = 1'b0;
        repeat (busyWait) begin
            @(posedge clock); #1;
            check("busy controller no grant", flags, 8'd0);
        end
        bus.iCtl_idle = 1'b1;
        for (int k = 0; k < T; k++) begin
            @(posedge clock); #1;
            check("issue/wait flags", flags,
                  {1'b1, k == 0 && w == 0, k == 0 && w == 1, 1'b0, 1'b0, 1'b0, k <= hold, 1'b1});
            if (k == 0) begin
                check("latched operands", {bus.oCmd_index, bus.oCmd_argument}, w == 1 ? {i1, a1} : {i0, a0});
                if (w == 0) bus.iReq0 = 1'b0; else bus.iReq1 = 1'b0;
            end
            bus.iCtl_idle = k < hold;
            bus.iCmd_complete = k == kc;
            bus.iResponse = resp;
            bus.iIndex_error = ierr;
            if (k == kc || k == T - 1) break;
        end
        @(posedge clock); #1;
        if (timedOut) mTerr = 1'b1;
        else begin
            mResp = resp;
            mIerr = ierr;
            mTerr = 1'b0;
        end
        lastServed = w;
        check("done flags", flags, {1'b1, 1'b0, 1'b0, w == 0, w == 1, timedOut, 1'b0, 1'b0});
        check("done result", result, {mResp, mIerr, mTerr});
        bus.iCmd_complete = 1'b0;
        bus.iCtl_idle = 1'b1;
        @(posedge clock); #1;
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        check("back to idle", flags, 8'd0);
        check("result held", result, {mResp, mIerr, mTerr});
    endtask

    initial begin
        logic [1:0] r;
        int cd;
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        bus.iReq0_index = '0;
        bus.iReq1_index = '0;
        bus.iReq0_argument = '0;
        bus.iReq1_argument = '0;
        bus.iCtl_idle = 1'b1;
        bus.iCmd_complete = 1'b0;
        bus.iResponse = '0;
        bus.iIndex_error = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset flags", flags, 8'd0);
        check("reset result", result, 40'd0);
        check("reset operands", {bus.oCmd_index, bus.oCmd_argument}, 38'd0);
        resetN = 1'b1;

        // Contention straight after reset: grants alternate starting with requester 0.
        repeat (4) doCmd(1'b1, 1'b1, 6'd1, 6'd2, 32'hA0A0_0001, 32'hB0B0_0002, 0, 0, 1,
                         38'({$urandom, $urandom}), 1'b0);
        check("contention last served", 64'(lastServed), 64'd1);

        doCmd(1'b1, 1'b0, 6'd17, 6'd0, 32'h0000_0200, 32'h0, 0, 0, 0, 38'h11_0000_0900, 1'b0);
        check("single request response", 64'(bus.oResponse), 64'h11_0000_0900);

        // Timeout with no completion, completion one cycle too late, then the exact tie.
        doCmd(1'b1, 1'b0, 6'd3, 6'd0, 32'h3, 32'h0, 0, 0, -1, 38'h3F_FFFF_FFFF, 1'b1);
        doCmd(1'b0, 1'b1, 6'd0, 6'd4, 32'h0, 32'h4, 0, 0, T - 1, 38'h3F_FFFF_FFFF, 1'b1);
        doCmd(1'b1, 1'b0, 6'd5, 6'd0, 32'h5, 32'h0, 0, 0, T - 2, 38'h22_1234_5678, 1'b1);
        doCmd(1'b1, 1'b0, 6'd6, 6'd0, 32'h6, 32'h0, 0, 2, 0, 38'h01_0000_0001, 1'b0);

        // Busy controller holds off requester 1.
        doCmd(1'b0, 1'b1, 6'd0, 6'd42, 32'h0, 32'hCAFE_F00D, 3, 0, 2, 38'h2A_0000_0042, 1'b0);

        // A request dropped before the sampling edge is never granted.
        bus.iReq0 = 1'b1;
        #2 bus.iReq0 = 1'b0;
        @(posedge clock); #1;
        check("dropped request", flags, 8'd0);

        // Reset mid-WAIT abandons the command.
        bus.iReq0 = 1'b1;
        bus.iReq0_index = 6'd9;
        bus.iReq0_argument = 32'h99;
        @(posedge clock); #1;
        bus.iReq0 = 1'b0;
        bus.iCtl_idle = 1'b0;
        @(posedge clock); #1;
        check("in wait before reset", flags, 8'b1000_0001);
        resetN = 1'b0;
        #1;
        check("async reset flags", flags, 8'd0);
        check("async reset result", result, 40'd0);
        check("async reset operands", {bus.oCmd_index, bus.oCmd_argument}, 38'd0);
        @(posedge clock); #1;
        check("no done after reset", flags, 8'd0);
        resetN = 1'b1;
        bus.iCtl_idle = 1'b1;
        lastServed = 1;
        mResp = '0;
        mIerr = 1'b0;
        mTerr = 1'b0;
        doCmd(1'b1, 1'b1, 6'd11, 6'd12, 32'h11, 32'h12, 0, 0, 0, 38'h0A_0000_000A, 1'b0);
        check("post reset winner", 64'(lastServed), 64'd0);

        repeat (24) begin
            r = 2'($urandom_range(1, 3));
            cd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T));
            doCmd(r[0], r[1], 6'($urandom), 6'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), cd,
                  38'({$urandom, $urandom}), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
